wb_initiator: RTL and testbench

WB_INITIATOR -- requirements
Module: wb_initiator

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_timeout_cnt.sv | 47 ++++
 rtl/wb_initiator.sv | 156 +++++++++++++++
 tb/tb_wb_initiator.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// ============================================================================
// Module  : wb_pkg
// Brief   : Shared state encoding and default bus widths for wb_initiator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_pkg;

  localparam int WB_DEF_DATA_WIDTH = 32;
  localparam int WB_DEF_ADDR_WIDTH = 32;
  localparam int WB_DEF_SEL_WIDTH  = 4;
  localparam int WB_DEF_TIMEOUT    = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/wb_timeout_cnt.sv
// ============================================================================
// Module  : wb_timeout_cnt
// Brief   : Saturating bus-cycle counter; flags the cycle that reaches the limit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] C_LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != C_LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High in the bus cycle whose increment brings the count to the limit.
  assign expired_o = en_i && (cnt_q >= C_LAST);

endmodule

`default_nettype wire

// File: rtl/wb_initiator.sv
// ============================================================================
// Module  : wb_initiator
// Brief   : Single-outstanding Wishbone classic initiator with ack timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_initiator
  import wb_pkg::*;
#(
  parameter int WB_DATA_WIDTH  = WB_DEF_DATA_WIDTH,
  parameter int WB_ADDR_WIDTH  = WB_DEF_ADDR_WIDTH,
  parameter int WB_SEL_WIDTH   = WB_DEF_SEL_WIDTH,
  parameter int TIMEOUT_CYCLES = WB_DEF_TIMEOUT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] req_data_i,
  input  logic [WB_SEL_WIDTH-1:0]  req_sel_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WB_DATA_WIDTH-1:0] rsp_data_o,
  output logic                     rsp_err_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
  output logic                     wb_we_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  input  logic                     wb_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i
);

  wb_state_e                state_q,     state_d;
  logic [WB_ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [WB_DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic [WB_SEL_WIDTH-1:0]  sel_q,       sel_d;
  logic                     we_q,        we_d;
  logic                     cyc_q,       cyc_d;
  logic [WB_DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic                     rsp_err_q,   rsp_err_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     ready_q,     ready_d;

  logic cnt_clr;
  logic cnt_en;
  logic expired;

  wb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .expired_o(expired)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    we_d       = we_q;
    cyc_d      = cyc_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          wdata_d = req_data_i;
          sel_d   = req_sel_i;
          we_d    = req_we_i;
          cyc_d   = 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        cnt_en = 1'b1;
        // Ack takes priority over a coincident timeout.
        if (wb_ack_i) begin
          cyc_d      = 1'b0;
          rsp_data_d = we_q ? '0 : wb_data_i;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (expired) begin
          cyc_d      = 1'b0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase

    ready_d     = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign wb_addr_o   = addr_q;
  assign wb_data_o   = wdata_q;
  assign wb_sel_o    = sel_q;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_initiator.sv
// ============================================================================
// Module  : tb_wb_initiator
// Brief   : Timeline-model self-checking bench for wb_initiator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_initiator;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_data_i = '0;
  logic [3:0]  req_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic [31:0] wb_data_i = '0;

  always #5 clk = ~clk;

  wb_initiator #(
    .WB_DATA_WIDTH (32),
    .WB_ADDR_WIDTH (32),
    .WB_SEL_WIDTH  (4),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_we_i   (req_we_i),
    .req_addr_i (req_addr_i),
    .req_data_i (req_data_i),
    .req_sel_i  (req_sel_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_data_o (rsp_data_o),
    .rsp_err_o  (rsp_err_o),
    .wb_addr_o  (wb_addr_o),
    .wb_data_o  (wb_data_o),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_ack_i   (wb_ack_i),
    .wb_data_i  (wb_data_i)
  );

  int checks = 0;
  int errors = 0;
  int e = 0;

  always @(posedge clk) e <= e + 1;

  // Timeline of the current transaction, in rising-edge numbers.
  bit          checking = 0;
  bit          zero_mode = 1;
  bit          have_txn = 0;
  int          t_a, t_len, t_r, t_rst;
  logic        t_we, t_err;
  logic [31:0] t_addr, t_wdata, t_rsp;
  logic [3:0]  t_sel;

  int          cyc_cnt, valid_cnt, first_valid;
  logic [31:0] first_data;
  logic        first_err, first_we;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, e);
    end
  endtask

  always @(negedge clk) begin
    bit zero_st, bus_st, resp_st;
    if (checking) begin
      zero_st = zero_mode || (have_txn && e >= t_rst);
      bus_st  = !zero_st && have_txn && (e < t_a + t_len);
      resp_st = !zero_st && have_txn && !bus_st && (e < t_r);

      if (wb_cyc_o) begin
        cyc_cnt++;
        first_we = wb_we_o;
      end
      if (rsp_valid_o) begin
        valid_cnt++;
        if (first_valid < 0) begin
          first_valid = e;
          first_data  = rsp_data_o;
          first_err   = rsp_err_o;
        end
      end

      chk("req_ready", req_ready_o, !(bus_st || resp_st));
      chk("wb_cyc", wb_cyc_o, bus_st);
      chk("wb_stb", wb_stb_o, bus_st);
      chk("rsp_valid", rsp_valid_o, resp_st);
      if (bus_st) begin
        chk("wb_addr", wb_addr_o, t_addr);
        chk("wb_data", wb_data_o, t_wdata);
        chk("wb_sel", wb_sel_o, t_sel);
        chk("wb_we", wb_we_o, t_we);
      end
      if (resp_st) begin
        chk("rsp_data", rsp_data_o, t_rsp);
        chk("rsp_err", rsp_err_o, t_err);
      end
      if (zero_st) begin
        chk("rst_addr", wb_addr_o, 0);
        chk("rst_wdata", wb_data_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_rsp_data", rsp_data_o, 0);
        chk("rst_rsp_err", rsp_err_o, 0);
      end
    end
  end

  // k: bus-cycle index (0 = first cycle with cyc high) in which the slave acks, -1 = never.
  // rst_at: bus-cycle index in which rst_i is held high, -1 = none.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, input int k, input logic [31:0] rdata,
                         input int rdelay, input int rst_at);
    bit acked;
    int nloop;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_data_i  = wdata;
    req_sel_i   = sel;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    req_addr_i  = 32'hFFFF_FFFF;
    req_data_i  = 32'hFFFF_FFFF;

    acked     = (k >= 0) && (k < T);
    t_a       = e;
    t_len     = acked ? k + 1 : T;
    t_r       = t_a + t_len + rdelay + 1;
    t_rst     = (rst_at >= 0) ? t_a + rst_at + 1 : 32'h7FFF_FFFF;
    t_we      = we;
    t_addr    = addr;
    t_wdata   = wdata;
    t_sel     = sel;
    t_err     = !acked;
    t_rsp     = (!acked || we) ? 32'h0 : rdata;
    have_txn  = 1;
    zero_mode = 0;
    cyc_cnt = 0; valid_cnt = 0; first_valid = -1;

    nloop = (rst_at >= 0) ? k + 1 : t_len;
    for (int i = 0; i < nloop; i++) begin
      wb_ack_i  = (i == k);
      wb_data_i = (i == k) ? rdata : (32'hBAD0_0000 | i);
      rst_i     = (i == rst_at);
      @(posedge clk); #1;
    end
    wb_ack_i = 1'b0;
    rst_i    = 1'b0;
    if (rst_at < 0) begin
      repeat (rdelay) begin
        @(posedge clk); #1;
      end
      rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      rsp_ready_i = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_i    = 1'b0;
    checking = 1;
    chk("reset_ready", req_ready_o, 1);
    chk("reset_cyc", wb_cyc_o, 0);
    repeat (2) @(posedge clk);
    #1;

    // Write, ack in the cycle after cyc rises: valid sampled at N+3.
    run_txn(1'b1, 32'h0, 32'h0000_0010, 4'hF, 1, 32'h1111_2222, 0, -1);
    chk("w_valid_latency", first_valid - t_a, 2);
    chk("w_cyc_cycles", cyc_cnt, 2);
    chk("w_we", first_we, 1);
    chk("w_err", first_err, 0);
    chk("w_data", first_data, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // Read with 3-cycle ack delay.
    run_txn(1'b0, 32'h4, 32'h0, 4'hF, 3, 32'hDEAD_BEEF, 1, -1);
    chk("r_data", first_data, 32'hDEAD_BEEF);
    chk("r_cyc_cycles", cyc_cnt, 4);
    chk("r_valid_cycles", valid_cnt, 2);
    repeat (1) @(posedge clk);
    #1;

    // Slave never acks.
    run_txn(1'b0, 32'h8, 32'h0, 4'h1, -1, 32'h0, 0, -1);
    chk("to_cyc_cycles", cyc_cnt, 8);
    chk("to_err", first_err, 1);
    chk("to_data", first_data, 32'h0);

    // Stray acks while idle.
    wb_ack_i  = 1'b1;
    wb_data_i = 32'h5555_AAAA;
    repeat (3) @(posedge clk);
    #1;
    wb_ack_i = 1'b0;

    // Ack on the timeout cycle, response held for 5 cycles.
    run_txn(1'b0, 32'hC, 32'h0, 4'hC, T - 1, 32'h1234_5678, 5, -1);
    chk("edge_err", first_err, 0);
    chk("edge_data", first_data, 32'h1234_5678);
    chk("edge_cyc_cycles", cyc_cnt, 8);
    chk("edge_valid_cycles", valid_cnt, 6);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-bus, late ack afterwards.
    run_txn(1'b1, 32'h20, 32'hCAFE_F00D, 4'h6, 2, 32'h7777_7777, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_valid", first_valid, -1);
    chk("rst_cyc_cycles", cyc_cnt, 2);
    chk("rst_ready", req_ready_o, 1);

    // Normal operation resumes after reset.
    run_txn(1'b0, 32'h30, 32'h0, 4'h3, 0, 32'hA5A5_5A5A, 0, -1);
    chk("post_data", first_data, 32'hA5A5_5A5A);
    chk("post_cyc_cycles", cyc_cnt, 1);
    repeat (2) @(posedge clk);
    #1;

    checking = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
